// File: rtl/wide_add_sequencer_if.sv
// Handshake and adder-port bundle for wide_add_sequencer.
// slave is the sequencer's view; master is the environment driving requests and the 6-bit adder.
interface wide_add_sequencer_if #(
  parameter int NCHUNK = 4
);
  localparam int W = 6 * NCHUNK;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic [5:0]   add_x;
  logic [5:0]   add_y;
  logic         add_cin;
  logic [5:0]   add_s;
  logic         add_cout;

  modport slave (
    input  in_valid, a, b, cin, out_ready, add_s, add_cout,
    output in_ready, out_valid, sum, cout, add_x, add_y, add_cin
  );

  modport master (
    output in_valid, a, b, cin, out_ready, add_s, add_cout,
    input  in_ready, out_valid, sum, cout, add_x, add_y, add_cin
  );
endinterface

// File: rtl/wide_add_sequencer.sv
// Adds two W = 6*NCHUNK bit operands by streaming one 6-bit chunk per cycle,
// LSB first, through an external combinational 6-bit adder.
module wide_add_sequencer #(
  parameter int NCHUNK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  wide_add_sequencer_if.slave   bus
);
  localparam int W  = 6 * NCHUNK;
  localparam int KW = (NCHUNK > 2) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic [5:0]    a_chunk, b_chunk;
  logic          run;

  assign run = (state_q == RUN);

  // Chunk k of each operand register, selected by an explicit mux.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (k_q == KW'(i)) begin
        a_chunk = a_q[6*i +: 6];
        b_chunk = b_q[6*i +: 6];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NCHUNK; i++) begin
          if (k_q == KW'(i)) sum_d[6*i +: 6] = bus.add_s;
        end
        carry_d = bus.add_cout;
        if (k_q == KLAST) begin
          cout_d  = bus.add_cout;
          state_d = DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Adder ports are forced to zero whenever no chunk is in flight.
  assign bus.add_x     = run ? a_chunk : 6'd0;
  assign bus.add_y     = run ? b_chunk : 6'd0;
  assign bus.add_cin   = run ? carry_q : 1'b0;
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer with a behavioural 6-bit adder
// and a plain-arithmetic reference for the wide sum.
module tb_wide_add_sequencer;
  localparam int NCHUNK = 4;
  localparam int W      = 6 * NCHUNK;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  wide_add_sequencer_if #(.NCHUNK(NCHUNK)) bus ();

  wide_add_sequencer #(.NCHUNK(NCHUNK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // External 6-bit adder: purely combinational.
  assign {bus.add_cout, bus.add_s} = {1'b0, bus.add_x} + {1'b0, bus.add_y} + {6'd0, bus.add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  // Drives one request, scrambles the inputs after acceptance, waits for the
  // result, optionally stalls, then completes the output handshake.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tc,
                        input int stall, output logic [W-1:0] rs, output logic rc,
                        output int lat, output logic [NCHUNK-1:0] ctrace, output bit ok);
    int g;
    ok = 1'b1; rs = '0; rc = 1'b0; lat = 0; ctrace = '0;
    g = 0;
    while (!bus.in_ready && g < 50) begin @(negedge clk); g++; end
    if (!bus.in_ready) begin ok = 1'b0; return; end
    bus.in_valid = 1'b1; bus.a = ta; bus.b = tbv; bus.cin = tc;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
    while (!bus.out_valid && lat < 50) begin
      if (lat < NCHUNK) ctrace[lat] = bus.add_cin;
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) begin ok = 1'b0; return; end
    rs = bus.sum; rc = bus.cout;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      if (bus.sum !== rs || bus.cout !== rc || bus.out_valid !== 1'b1) ok = 1'b0;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.a = 24'hFFFFFF; bus.b = 24'hFFFFFF; bus.cin = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.sum !== '0 || bus.cout !== 1'b0
        || bus.add_x !== 6'd0 || bus.add_y !== 6'd0 || bus.add_cin !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b sum=%h cout=%b add_x=%h add_y=%h add_cin=%b, want 1 0 000000 0 00 00 0",
               bus.in_ready, bus.out_valid, bus.sum, bus.cout, bus.add_x, bus.add_y, bus.add_cin);
    end
    bus.in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_no_accept: in_ready=%b want 1", bus.in_ready);
    end
  endtask

  task automatic test_ripple();
    logic [W-1:0] rs; logic rc; int lat; logic [NCHUNK-1:0] tr; bit ok;
    run_op(24'hFFFFFF, 24'h000001, 1'b0, 0, rs, rc, lat, tr, ok);
    n_tests++;
    if (!ok || lat != NCHUNK || rs !== 24'h000000 || rc !== 1'b1) begin
      n_fail++;
      $display("FAIL ripple: ok=%0d lat=%0d sum=%h cout=%b, want ok=1 lat=%0d sum=000000 cout=1", ok, lat, rs, rc, NCHUNK);
    end
    n_tests++;
    if (tr !== 4'b1110) begin
      n_fail++;
      $display("FAIL ripple_carry_chain: add_cin trace(k3..k0)=%b want 1110", tr);
    end
  endtask

  task automatic test_mixed();
    logic [W-1:0] rs; logic rc; int lat; logic [NCHUNK-1:0] tr; bit ok;
    run_op(24'h123456, 24'h654321, 1'b1, 0, rs, rc, lat, tr, ok);
    n_tests++;
    if (!ok || rs !== 24'h777778 || rc !== 1'b0) begin
      n_fail++;
      $display("FAIL mixed: ok=%0d sum=%h cout=%b, want sum=777778 cout=0", ok, rs, rc);
    end
    n_tests++;
    if (tr !== 4'b0001) begin
      n_fail++;
      $display("FAIL mixed_add_cin: trace(k3..k0)=%b want 0001", tr);
    end
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.add_x !== 6'd0 || bus.sum !== 24'h777778) begin
      n_fail++;
      $display("FAIL mixed_idle_after: in_ready=%b add_x=%h sum=%h want 1 00 777778", bus.in_ready, bus.add_x, bus.sum);
    end
  endtask

  task automatic test_backpressure();
    logic [W:0] exp; int g; bit stable;
    exp = ref_add(24'hA5A5A5, 24'h5A5A5B, 1'b0);
    bus.in_valid = 1'b1; bus.a = 24'hA5A5A5; bus.b = 24'h5A5A5B; bus.cin = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    g = 0;
    while (!bus.out_valid && g < 50) begin @(negedge clk); g++; end
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1; bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
      @(negedge clk);
      if (bus.sum !== exp[W-1:0] || bus.cout !== exp[W] || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1)
        stable = 1'b0;
    end
    n_tests++;
    if (!stable) begin
      n_fail++;
      $display("FAIL backpressure_hold: sum=%h cout=%b in_ready=%b out_valid=%b, want sum=%h cout=%b 0 1",
               bus.sum, bus.cout, bus.in_ready, bus.out_valid, exp[W-1:0], exp[W]);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.sum !== exp[W-1:0]) begin
      n_fail++;
      $display("FAIL backpressure_release: in_ready=%b out_valid=%b sum=%h, want 1 0 %h", bus.in_ready, bus.out_valid, bus.sum, exp[W-1:0]);
    end
  endtask

  task automatic test_reset_mid_run();
    bit quiet;
    bus.in_valid = 1'b1; bus.a = 24'hABCDEF; bus.b = 24'h111111; bus.cin = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.sum !== '0 || bus.cout !== 1'b0
        || bus.add_x !== 6'd0 || bus.add_y !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_mid_run: in_ready=%b out_valid=%b sum=%h cout=%b add_x=%h add_y=%h, want 1 0 000000 0 00 00",
               bus.in_ready, bus.out_valid, bus.sum, bus.cout, bus.add_x, bus.add_y);
    end
    quiet = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) quiet = 1'b0;
    end
    n_tests++;
    if (!quiet) begin
      n_fail++;
      $display("FAIL reset_abort_no_valid: out_valid pulsed=1 want 0");
    end
  endtask

  task automatic test_back_to_back();
    int g;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.a = 24'h800000; bus.b = 24'h800000; bus.cin = 1'b0;
    @(negedge clk);
    bus.a = 24'h000001; bus.b = 24'h000002; bus.cin = 1'b0;
    g = 0;
    while (!bus.out_valid && g < 50) begin @(negedge clk); g++; end
    n_tests++;
    if (g != NCHUNK || bus.sum !== 24'h000000 || bus.cout !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first: lat=%0d sum=%h cout=%b, want %0d 000000 1", g, bus.sum, bus.cout, NCHUNK);
    end
    @(negedge clk);
    n_tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_handshake_idle: in_ready=%b out_valid=%b, want 1 0", bus.in_ready, bus.out_valid);
    end
    @(negedge clk);
    n_tests++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second_accept: in_ready=%b want 0", bus.in_ready);
    end
    g = 0;
    while (!bus.out_valid && g < 50) begin @(negedge clk); g++; end
    bus.in_valid = 1'b0;
    n_tests++;
    if (g != NCHUNK || bus.sum !== 24'h000003 || bus.cout !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second: lat=%0d sum=%h cout=%b, want %0d 000003 0", g, bus.sum, bus.cout, NCHUNK);
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [W-1:0] ta, tbv, rs; logic tc, rc; int lat; logic [NCHUNK-1:0] tr; bit ok;
    logic [W:0] exp;
    for (int n = 0; n < 1000; n++) begin
      ta = W'($urandom); tbv = W'($urandom); tc = 1'($urandom);
      if (n % 50 == 0) tbv = ~ta;
      exp = ref_add(ta, tbv, tc);
      n_tests++;
      if (bus.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL random_spurious_valid #%0d: out_valid=%b want 0", n, bus.out_valid);
      end
      run_op(ta, tbv, tc, int'($urandom_range(0, 3)), rs, rc, lat, tr, ok);
      n_tests++;
      if (!ok || lat != NCHUNK || {rc, rs} !== exp) begin
        n_fail++;
        $display("FAIL random #%0d: a=%h b=%h cin=%b ok=%0d lat=%0d got=%h want=%h",
                 n, ta, tbv, tc, ok, lat, {rc, rs}, exp);
      end
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_ripple();
    test_mixed();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/wide_add_sequencer.md
WIDE_ADD_SEQUENCER -- requirements
Module: wide_add_sequencer

Interface
REQ-001 The block SHALL have one parameter: NCHUNK, default 4, the number of 6-bit chunks per operand (operand width W = 6*NCHUNK, NCHUNK >= 2).
REQ-002 The block SHALL have a single clock and a synchronous, active-high reset, with ports as listed below.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand request valid.
REQ-006 in_ready  output  1  block can accept an operand request.
REQ-007 a  input  W  first operand.
REQ-008 b  input  W  second operand.
REQ-009 cin  input  1  carry into bit 0.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 sum  output  W  result bits.
REQ-013 cout  output  1  carry out of bit W-1.
REQ-014 add_x  output  6  chunk of a, driven to the external 6-bit prefix adder X port.
REQ-015 add_y  output  6  chunk of b, driven to the adder Y port.
REQ-016 add_cin  output  1  carry driven to the adder c_in port.
REQ-017 add_s  input  6  sum returned by the adder S port (combinational path from add_x, add_y and add_cin).
REQ-018 add_cout  input  1  carry returned by the adder c_out port.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-020 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-021 In IDLE, when in_valid = 1, the block SHALL register a, b and cin, clear the chunk counter k to 0, load the carry register with cin, and enter RUN on the same edge.
REQ-022 In RUN, during each cycle, add_x SHALL equal a_reg[6k+5:6k], add_y SHALL equal b_reg[6k+5:6k], and add_cin SHALL equal the carry register.
REQ-023 At the end of each RUN cycle, the block SHALL store add_s into sum[6k+5:6k], load add_cout into the carry register, and increment k.
REQ-024 When k = NCHUNK-1 at the end of a RUN cycle, the block SHALL store that cycle's add_cout into cout and enter DONE; k SHALL never exceed NCHUNK-1.
REQ-025 Latency SHALL be fixed: with acceptance on edge T, out_valid SHALL first be 1 in the cycle following edge T+NCHUNK.
REQ-026 In DONE, sum and cout SHALL remain stable until out_valid and out_ready are both 1 on a rising edge.
REQ-027 On that handshake, the block SHALL return to IDLE; in_ready SHALL therefore be 1 one cycle after the output handshake, and a new request SHALL NOT be accepted in the handshake cycle.
REQ-028 in_valid and the a, b and cin inputs SHALL be ignored in RUN and DONE; changes to a, b or cin after acceptance SHALL NOT affect the result.
REQ-029 Outside RUN, add_x, add_y and add_cin SHALL be 0.
REQ-030 sum and cout SHALL equal (a + b + cin) mod 2^(W+1), split as {cout, sum}.
REQ-031 sum and cout SHALL hold their last values in IDLE and while in RUN until overwritten.

Reset
REQ-032 When rst = 1 on an edge, the block SHALL enter IDLE and clear all of the following to 0: k, the carry register, a_reg, b_reg, sum, cout and out_valid; in_ready SHALL be 1 in the following cycle.
REQ-033 Reset SHALL take priority over every other event, including reset asserted mid-RUN or in DONE; an aborted operation SHALL produce no out_valid pulse.
REQ-034 A request with in_valid = 1 while rst = 1 SHALL NOT be accepted.

Verification
REQ-035 Full ripple: a=0xFFFFFF, b=0x000001, cin=0, NCHUNK=4 -> carry propagates through all chunks; out_valid 4 edges after acceptance; sum=0x000000, cout=1.
REQ-036 Mixed: a=0x123456, b=0x654321, cin=1 -> sum=0x777778, cout=0; add_cin observed as 1,0,0,0 across the 4 RUN cycles.
REQ-037 Backpressure: hold out_ready=0 for 5 cycles in DONE with a new in_valid=1 and changing a and b -> sum and cout stable, in_ready=0, no acceptance; out_ready=1 -> IDLE the next cycle.
REQ-038 Reset mid-RUN: assert rst after 2 RUN cycles -> next cycle IDLE, sum=0, cout=0, out_valid=0, in_ready=1, add_x=add_y=0.
REQ-039 Back-to-back: 0x800000+0x800000, cin=0 (-> sum 0, cout 1) then 0x000001+0x000002, cin=0 (-> sum 3, cout 0) with out_ready tied to 1 -> second acceptance exactly 1 cycle after the first output handshake.
REQ-040 Random: 1000 random a, b and cin with random out_ready stalls -> every result matches a + b + cin; out_valid never asserts without a preceding acceptance.
